// File: rtl/cobra_disp_pkg.sv
// cobra_disp_pkg: shared constants and types for the hex display stage
package cobra_disp_pkg;

    localparam int DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/cobra_hex_display_hex7seg.sv
// hex7seg: combinational nibble to active-low 7-segment decoder
module hex7seg
    import cobra_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/cobra_hex_display.sv
// cobra_hex_display: scanned 8-digit hex display with per-frame shadow capture
module cobra_hex_display
    import cobra_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_i,
    input  logic        freeze_i,
    input  logic        blank_lz_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        update_o
);

    logic [23:0] div_q;
    digit_idx_t  idx_q;
    logic [31:0] shadow_q;
    logic        tick;
    logic        frame_end;
    logic [3:0]  nib;
    logic [6:0]  hex_seg;
    logic [31:0] upper;
    logic        blank;

    assign tick      = div_q == 24'(SCAN_DIV - 1);
    assign frame_end = tick && idx_q == 3'(DIGITS - 1);
    assign nib       = shadow_q[{idx_q, 2'b00} +: 4];
    assign upper     = shadow_q >> {idx_q, 2'b00};
    assign blank     = blank_lz_i && idx_q != '0 && upper == '0;
    assign dp_o      = 1'b1;

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (hex_seg)
    );

    // Slot divider and digit index; index advances once per slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 24'd1;
            idx_q <= tick ? idx_q + 3'd1 : idx_q;
        end
    end

    // Shadow reload at frame end so a frame never mixes two values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            update_o <= 1'b0;
        end else begin
            shadow_q <= (frame_end && !freeze_i) ? data_i : shadow_q;
            update_o <= frame_end && !freeze_i;
        end
    end

    // Registered anode and segment drive for the current digit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_o  <= 8'hFF;
            seg_o <= SEG_BLANK;
        end else begin
            an_o  <= ~(8'b1 << idx_q);
            seg_o <= blank ? SEG_BLANK : hex_seg;
        end
    end

endmodule

// File: doc/cobra_hex_display.md
# cobra_hex_display

Downstream display stage for the CYBERcobra core. Consumes the core's 32-bit `out_o` value and shows it as 8 hexadecimal digits on a time-multiplexed, common-anode 7-segment display. Holds a tear-free shadow copy that is refreshed once per scan frame, with optional freeze and leading-zero blanking.

## Interface
Parameters:
- `SCAN_DIV`, default 100_000: clock cycles per digit slot. Legal range is 1 to 2^24-1.

Ports:
- `clk_i`  in  1: system clock.
- `rst_ni`  in  1: reset. Asynchronous, active-low.
- `data_i`  in  32: value to display. Driven from CYBERcobra `out_o`.
- `freeze_i`  in  1: when high, the shadow register is not reloaded.
- `blank_lz_i`  in  1: when high, leading zero digits are blanked.
- `an_o`  out  8: digit anodes, active-low, one-hot. Bit k selects digit k; digit 0 is the least significant nibble.
- `seg_o`  out  7: segments in `{g,f,e,d,c,b,a}` order, active-low.
- `dp_o`  out  1: decimal point, active-low. Constant 1 (off).
- `update_o`  out  1: one-cycle pulse when the shadow register loads.

## Operation
- **Divider** `div_q` counts 0..SCAN_DIV-1 and wraps to 0. `tick` = (`div_q` == SCAN_DIV-1).
- **Digit index** `idx_q` (3 bits) increments on `tick` and wraps 7→0.
- **Frame end** = `tick` && `idx_q`==7.
  - On frame end with `freeze_i`=0: `shadow_q` <= `data_i` and `update_o` <= 1.
  - Otherwise `update_o` <= 0.
- **Nibble select:** `nib` = `shadow_q[4*idx_q +: 4]`.
- **Hex decode** (active-low gfedcba): 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
- **Blanking:** digit k is blank when `blank_lz_i`=1, k≠0, and `shadow_q[31:4k]`==0.
  - Blank digit: `seg_o`=7'h7F, but its anode is still driven.
  - Digit 0 is never blanked.
- **Output registers:** `an_o`, `seg_o` and `update_o` are registered.
  - `an_o` <= ~(8'b1 << `idx_q`).
  - `seg_o` <= blank ? 7'h7F : decode(`nib`).
  - These update every cycle from the current `idx_q` and `shadow_q`.

## Timing
- **Reset values:** `div_q`=0, `idx_q`=0, `shadow_q`=0, `an_o`=8'hFF, `seg_o`=7'h7F, `dp_o`=1, `update_o`=0.
- **First edge after reset release:** `an_o`=8'hFE, `seg_o`=7'h40 (digit 0 shows "0").
- **Display latency:** `an_o`/`seg_o` reflect a change of `idx_q` or `shadow_q` exactly 1 cycle later.
- **Frame:** each digit is held SCAN_DIV cycles; a frame is 8·SCAN_DIV cycles.
- **Capture timing:**
  - `data_i` is sampled only at the frame-end edge, so changes mid-frame are invisible until the next frame.
  - `update_o` is high in the same cycle the new `shadow_q` is visible.
  - The new value first appears on the display (digit 0) one cycle later.
- **`freeze_i`** is sampled only at frame end. Asserting it at that edge suppresses both the load and `update_o`.
- **SCAN_DIV=1:** `tick` is asserted every cycle, the digit changes every cycle, and frame end occurs every 8 cycles.
- **Reset mid-frame:** all state returns immediately to reset values, with no glitch beyond the async clear.
- `data_i` is synchronous to `clk_i`. No synchronizer is needed.

## Structure
- **Package `cobra_disp_pkg`:**
  - `DIGITS`=8.
  - `SEG_BLANK`=7'h7F.
  - `localparam logic [6:0] HEX_SEG [16]` decode constants.
  - `typedef logic [2:0] digit_idx_t`.
- **Sub-module `hex7seg`:** combinational 4-bit → 7-bit active-low decoder using `HEX_SEG`. Instantiated once on `nib`.
- **Top:** divider, index counter, shadow register, blanking logic and output registers.

## Test plan
All scenarios use SCAN_DIV=4.
1. **Reset:** hold `rst_ni`=0 → `an_o`=FF, `seg_o`=7F, `update_o`=0. Release → next edge `an_o`=FE, `seg_o`=40.
2. **Capture and scan:** `data_i`=32'h89AB_CDEF, `freeze_i`=0.
   - `update_o` pulses at cycle 31 after reset.
   - Over the next 32 cycles, digits 0..7 show 0E, 06, 21, 46, 03, 08, 10, 00 with anodes FE, FD, …, 7F, each held 4 cycles.
3. **Mid-frame change:** change `data_i` to 0 at cycle 40 → display keeps 89ABCDEF until the next frame end. The following frame shows all 40.
4. **Freeze:** `freeze_i`=1 across a frame end → no `update_o` pulse; `shadow_q` unchanged while `data_i` changes.
5. **Blanking:** `data_i`=32'h0000_0A05, `blank_lz_i`=1 → digits 0..2 show 12, 40, 08; digits 3..7 show 7F.
   - `data_i`=0 → digit 0 shows 40; all other digits 7F.
6. **Async reset mid-frame:** assert `rst_ni` between clock edges at `idx_q`=5 → outputs go to reset values immediately, without waiting for a clock edge.
